// File: rtl/ip_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a single ip_send engine.
// Sequences start/length, routes data requests, and adds an inter-frame gap and a watchdog.
module ip_tx_arbiter #(
  parameter int unsigned IFG_CYCLES     = 12,
  parameter int unsigned MAX_BYTES      = 1472,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_start_en,
  input  logic [10:0] req0_byte_num,
  input  logic [31:0] req0_data,
  output logic        req0_tx_req,
  output logic        req0_tx_done,
  input  logic        req1_start_en,
  input  logic [10:0] req1_byte_num,
  input  logic [31:0] req1_data,
  output logic        req1_tx_req,
  output logic        req1_tx_done,
  output logic        ip_tx_start_en,
  output logic [10:0] ip_tx_byte_num,
  output logic [31:0] ip_tx_data,
  input  logic        ip_tx_req,
  input  logic        ip_tx_done,
  output logic        err_len,
  output logic        err_timeout,
  output logic        grant
);

  localparam int unsigned LEN_W   = 11;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > IFG_CYCLES) ? TIMEOUT_CYCLES : IFG_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_GAP} state_t;

  state_t             r_state;
  logic [1:0]         r_en;
  logic [1:0]         r_en_d;
  logic [LEN_W-1:0]   r_bn0;
  logic [LEN_W-1:0]   r_bn1;
  logic [LEN_W-1:0]   r_len0;
  logic [LEN_W-1:0]   r_len1;
  logic [1:0]         r_pending;
  logic               r_err_len;
  logic               r_grant;
  logic               r_rr;
  logic [LEN_W-1:0]   r_byte_num;
  logic               r_start_en;
  logic               r_done0;
  logic               r_done1;
  logic               r_err_to;
  logic [CNT_W-1:0]   r_cnt;

  logic [1:0] w_rise;
  logic [1:0] w_len_ok;
  logic [1:0] w_new;
  logic [1:0] w_bad;
  logic       w_done_hit;
  logic       w_to_hit;
  logic       w_end;
  logic [1:0] w_clr;
  logic       w_pick;
  logic       w_send;
  logic       w_active;

  // Request side: sampled level/length, rise detection, legality, pending flags
  assign w_rise      = r_en & ~r_en_d;
  assign w_len_ok[0] = (r_bn0 != '0) && (r_bn0 <= MAX_LEN);
  assign w_len_ok[1] = (r_bn1 != '0) && (r_bn1 <= MAX_LEN);
  assign w_new       = w_rise & ~r_pending & w_len_ok;
  assign w_bad       = w_rise & ~r_pending & ~w_len_ok;

  assign w_send      = (r_state == S_SEND);
  assign w_active    = (r_state == S_START) || w_send;
  assign w_done_hit  = w_send && ip_tx_done;
  assign w_to_hit    = w_send && !ip_tx_done && (r_cnt == TO_LAST);
  assign w_end       = w_done_hit || w_to_hit;
  assign w_clr       = w_end ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign w_pick      = (r_pending == 2'b11) ? r_rr : r_pending[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en      <= '0;
      r_en_d    <= '0;
      r_bn0     <= '0;
      r_bn1     <= '0;
      r_len0    <= '0;
      r_len1    <= '0;
      r_pending <= '0;
      r_err_len <= 1'b0;
    end else begin
      r_en      <= {req1_start_en, req0_start_en};
      r_en_d    <= r_en;
      r_bn0     <= req0_byte_num;
      r_bn1     <= req1_byte_num;
      r_pending <= (r_pending & ~w_clr) | w_new;
      r_err_len <= |w_bad;
      if (w_new[0]) r_len0 <= r_bn0;
      if (w_new[1]) r_len1 <= r_bn1;
    end
  end

  // Grant sequencer; one counter serves both the watchdog and the gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= 1'b0;
      r_rr       <= 1'b0;
      r_byte_num <= '0;
      r_start_en <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_err_to   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_start_en <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_err_to   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|r_pending) begin
            r_grant    <= w_pick;
            r_byte_num <= w_pick ? r_len1 : r_len0;
            r_start_en <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_end) begin
            r_done0    <= ~r_grant;
            r_done1    <= r_grant;
            r_err_to   <= w_to_hit;
            r_rr       <= ~r_grant;
            r_byte_num <= '0;
            r_cnt      <= '0;
            r_state    <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == IFG_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data-path routing to/from the granted requester is combinational
  assign ip_tx_data     = w_active ? (r_grant ? req1_data : req0_data) : DATA_W'(0);
  assign req0_tx_req    = w_send && !r_grant && ip_tx_req;
  assign req1_tx_req    = w_send &&  r_grant && ip_tx_req;

  assign ip_tx_start_en = r_start_en;
  assign ip_tx_byte_num = r_byte_num;
  assign req0_tx_done   = r_done0;
  assign req1_tx_done   = r_done1;
  assign err_len        = r_err_len;
  assign err_timeout    = r_err_to;
  assign grant          = r_grant;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed bench for ip_tx_arbiter; ip_send is modelled by hand-driven req/done strobes.
module tb_ip_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_start_en;
  logic [10:0] req0_byte_num;
  logic [31:0] req0_data;
  logic        req0_tx_req;
  logic        req0_tx_done;
  logic        req1_start_en;
  logic [10:0] req1_byte_num;
  logic [31:0] req1_data;
  logic        req1_tx_req;
  logic        req1_tx_done;
  logic        ip_tx_start_en;
  logic [10:0] ip_tx_byte_num;
  logic [31:0] ip_tx_data;
  logic        ip_tx_req;
  logic        ip_tx_done;
  logic        err_len;
  logic        err_timeout;
  logic        grant;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_done0  = 0;
  int n_done1  = 0;
  int n_errlen = 0;

  ip_tx_arbiter #(
    .IFG_CYCLES    (12),
    .MAX_BYTES     (1472),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_start_en (req0_start_en),
    .req0_byte_num (req0_byte_num),
    .req0_data     (req0_data),
    .req0_tx_req   (req0_tx_req),
    .req0_tx_done  (req0_tx_done),
    .req1_start_en (req1_start_en),
    .req1_byte_num (req1_byte_num),
    .req1_data     (req1_data),
    .req1_tx_req   (req1_tx_req),
    .req1_tx_done  (req1_tx_done),
    .ip_tx_start_en(ip_tx_start_en),
    .ip_tx_byte_num(ip_tx_byte_num),
    .ip_tx_data    (ip_tx_data),
    .ip_tx_req     (ip_tx_req),
    .ip_tx_done    (ip_tx_done),
    .err_len       (err_len),
    .err_timeout   (err_timeout),
    .grant         (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (ip_tx_start_en) n_start++;
      if (req0_tx_done)   n_done0++;
      if (req1_tx_done)   n_done1++;
      if (err_len)        n_errlen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int budget, output int cyc);
    cyc = 0;
    while (ip_tx_start_en !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("start_seen", 64'(ip_tx_start_en), 64'd1);
  endtask

  task automatic pulse_done();
    ip_tx_done = 1'b1;
    tick();
    ip_tx_done = 1'b0;
  endtask

  int c;
  int snap_start;
  int snap_errlen;

  initial begin
    rst_n = 1'b0;
    req0_start_en = 1'b0; req0_byte_num = '0; req0_data = 32'h66778899;
    req1_start_en = 1'b0; req1_byte_num = '0; req1_data = 32'h11223344;
    ip_tx_req = 1'b0; ip_tx_done = 1'b0;
    tick(); tick();
    chk("reset_outputs", {ip_tx_start_en, ip_tx_byte_num, ip_tx_data, req0_tx_req, req0_tx_done,
                          req1_tx_req, req1_tx_done, err_len, err_timeout, grant}, 64'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Single request, held high for 20 cycles
    snap_start = n_start;
    req0_byte_num = 11'd1; req0_start_en = 1'b1;
    tick(); chk("lat_c1", 64'(ip_tx_start_en), 64'd0);
    tick(); chk("lat_c2", 64'(ip_tx_start_en), 64'd0);
    tick(); chk("lat_c3", 64'(ip_tx_start_en), 64'd1);
    chk("single_len", 64'(ip_tx_byte_num), 64'd1);
    chk("single_grant", 64'(grant), 64'd0);
    tick(); chk("start_one_cycle", 64'(ip_tx_start_en), 64'd0);
    tick();
    pulse_done();
    chk("single_done0", 64'(req0_tx_done), 64'd1);
    chk("single_done1", 64'(req1_tx_done), 64'd0);
    tick(); chk("done_one_cycle", 64'(req0_tx_done), 64'd0);
    for (int i = 0; i < 12; i++) tick();
    req0_start_en = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("single_start_count", 64'(n_start - snap_start), 64'd1);
    chk("single_done_count", 64'(n_done0), 64'd1);

    // Data routing for requester 0
    req0_byte_num = 11'd20; req0_start_en = 1'b1;
    wait_start(10, c);
    chk("route_latency", 64'(c), 64'd3);
    chk("route_len", 64'(ip_tx_byte_num), 64'd20);
    tick();
    ip_tx_req = 1'b1; #1;
    chk("route_req0_hi", 64'(req0_tx_req), 64'd1);
    chk("route_req1_lo", 64'(req1_tx_req), 64'd0);
    chk("route_data", 64'(ip_tx_data), 64'h66778899);
    ip_tx_req = 1'b0; #1;
    chk("route_req0_lo", 64'(req0_tx_req), 64'd0);
    tick();
    pulse_done();
    chk("route_data_idle", 64'(ip_tx_data), 64'd0);
    chk("route_len_idle", 64'(ip_tx_byte_num), 64'd0);
    req0_start_en = 1'b0;
    for (int i = 0; i < 16; i++) tick();

    // Contention right after reset: requester 0 wins, then requester 1
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    req0_byte_num = 11'd8;  req0_start_en = 1'b1;
    req1_byte_num = 11'd12; req1_start_en = 1'b1;
    wait_start(10, c);
    chk("cont_grant_a", 64'(grant), 64'd0);
    chk("cont_len_a", 64'(ip_tx_byte_num), 64'd8);
    tick(); tick();
    pulse_done();
    chk("cont_done0", 64'(req0_tx_done), 64'd1);
    wait_start(30, c);
    chk("cont_ifg_spacing", 64'(c + 1), 64'd14);
    chk("cont_grant_b", 64'(grant), 64'd1);
    chk("cont_len_b", 64'(ip_tx_byte_num), 64'd12);
    tick(); tick();
    pulse_done();
    chk("cont_done1", 64'(req1_tx_done), 64'd1);
    chk("cont_done0_quiet", 64'(req0_tx_done), 64'd0);
    req0_start_en = 1'b0; req1_start_en = 1'b0;

    // Fairness: req0 re-requests right after its done while req1 is pending
    tick();
    req0_byte_num = 11'd4; req0_start_en = 1'b1;
    wait_start(40, c);
    chk("fair_grant_1", 64'(grant), 64'd0);
    chk("fair_len_1", 64'(ip_tx_byte_num), 64'd4);
    tick();
    req0_start_en = 1'b0;
    req1_byte_num = 11'd5; req1_start_en = 1'b1;
    tick(); tick(); tick();
    pulse_done();
    chk("fair_done0", 64'(req0_tx_done), 64'd1);
    req0_byte_num = 11'd6; req0_start_en = 1'b1;
    wait_start(30, c);
    chk("fair_grant_2", 64'(grant), 64'd1);
    chk("fair_len_2", 64'(ip_tx_byte_num), 64'd5);
    tick();
    pulse_done();
    chk("fair_done1", 64'(req1_tx_done), 64'd1);
    wait_start(30, c);
    chk("fair_grant_3", 64'(grant), 64'd0);
    chk("fair_len_3", 64'(ip_tx_byte_num), 64'd6);
    tick();
    pulse_done();
    req0_start_en = 1'b0; req1_start_en = 1'b0;
    for (int i = 0; i < 16; i++) tick();

    // Illegal lengths: 0 and MAX_BYTES+1
    snap_start  = n_start;
    snap_errlen = n_errlen;
    req0_byte_num = 11'd0; req0_start_en = 1'b1;
    tick(); chk("errlen0_early", 64'(err_len), 64'd0);
    tick(); chk("errlen0_pulse", 64'(err_len), 64'd1);
    tick(); chk("errlen0_clear", 64'(err_len), 64'd0);
    req0_start_en = 1'b0; tick();
    req0_byte_num = 11'd1473; req0_start_en = 1'b1;
    tick(); tick(); chk("errlen_max_pulse", 64'(err_len), 64'd1);
    req0_start_en = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("errlen_count", 64'(n_errlen - snap_errlen), 64'd2);
    chk("errlen_no_start", 64'(n_start - snap_start), 64'd0);

    // Watchdog on a MAX_BYTES frame, then pending req1, then reset mid-SEND
    req0_byte_num = 11'd1472; req0_start_en = 1'b1;
    wait_start(10, c);
    chk("wd_len_max", 64'(ip_tx_byte_num), 64'd1472);
    tick();
    req1_byte_num = 11'd3; req1_start_en = 1'b1;
    for (int i = 0; i < 63; i++) tick();
    chk("wd_before", 64'(err_timeout), 64'd0);
    tick();
    chk("wd_err_timeout", 64'(err_timeout), 64'd1);
    chk("wd_done0", 64'(req0_tx_done), 64'd1);
    chk("wd_done1_quiet", 64'(req1_tx_done), 64'd0);
    tick();
    chk("wd_err_clear", 64'(err_timeout), 64'd0);
    wait_start(30, c);
    chk("wd_next_grant", 64'(grant), 64'd1);
    chk("wd_next_len", 64'(ip_tx_byte_num), 64'd3);
    tick();
    ip_tx_req = 1'b1; #1;
    chk("rst_pre_req1", 64'(req1_tx_req), 64'd1);
    chk("rst_pre_data", 64'(ip_tx_data), 64'h11223344);
    rst_n = 1'b0; #1;
    chk("rst_mid_send", {ip_tx_start_en, ip_tx_byte_num, ip_tx_data, req0_tx_req, req0_tx_done,
                         req1_tx_req, req1_tx_done, err_len, err_timeout, grant}, 64'd0);
    ip_tx_req = 1'b0;
    req0_start_en = 1'b0; req1_start_en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("rst_no_restart", 64'(ip_tx_start_en), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ip_tx_arbiter.md
Name: ip_tx_arbiter

Overview:
- Shares one ip_send transmit engine between two frame requesters: requester 0 is the UDP loop-back data path, requester 1 is the status/aux path.
- Latches start requests, grants them round-robin and sequences ip_send's start strobe and byte count.
- Routes ip_send's data request back to the granted requester, returns per-requester done pulses, and enforces an inter-frame gap and a completion watchdog.

Parameters:
IFG_CYCLES, 12, idle cycles inserted after each ip_tx_done before the next grant
MAX_BYTES, 1472, largest legal payload byte count
TIMEOUT_CYCLES, 4096, cycles in SEND without ip_tx_done before the frame is aborted

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req0_start_en  in  1  requester 0 start level; a rising edge is a request
req0_byte_num  in  11  requester 0 payload bytes, sampled on its rising edge
req0_data  in  32  requester 0 payload word
req0_tx_req  out  1  ip_tx_req forwarded when requester 0 is granted
req0_tx_done  out  1  one-cycle completion pulse to requester 0
req1_start_en  in  1  as req0
req1_byte_num  in  11  as req0
req1_data  in  32  as req0
req1_tx_req  out  1  as req0
req1_tx_done  out  1  as req0
ip_tx_start_en  out  1  one-cycle start strobe to ip_send
ip_tx_byte_num  out  11  byte count to ip_send
ip_tx_data  out  32  payload word to ip_send
ip_tx_req  in  1  ip_send data request
ip_tx_done  in  1  ip_send frame-complete pulse
err_len  out  1  one-cycle pulse: request rejected for illegal length
err_timeout  out  1  one-cycle pulse: frame aborted by watchdog
grant  out  1  requester currently or last served

Behaviour:
- Reset: clk and rst_n, asynchronous active-low. All outputs are 0. State is IDLE. Pending flags, edge registers and counters clear. The round-robin pointer favours requester 0 first.
- Edge detect: reqN_start_en is registered. A rise is start_en=1 with the previous sample=0. Held-high levels generate one request only.
- Capture on a rise: if byte_num is 0 or greater than MAX_BYTES, the request is dropped and err_len pulses the next cycle. Otherwise pending_N is set and len_N is captured.
- A rise while pending_N is already set is ignored. This includes during N's own frame. A new request from N is accepted from the cycle after reqN_tx_done.
- IDLE: if exactly one pending flag is set, grant that requester. If both are set, grant the one not served last. Go to START.
- START (1 cycle): ip_tx_start_en=1 and ip_tx_byte_num=len_grant. Go to SEND.
- SEND: ip_tx_byte_num holds len_grant.
  - Combinational routing: ip_tx_data=reqG_data, reqG_tx_req=ip_tx_req. The non-granted tx_req is 0.
  - On ip_tx_done: reqG_tx_done pulses 1 cycle (registered), pending_G clears, the round-robin pointer updates, and the state goes to GAP.
  - Watchdog: the counter runs from SEND entry. At TIMEOUT_CYCLES without done, err_timeout pulses, reqG_tx_done pulses (the frame is released), pending_G clears, and the state goes to GAP.
- GAP: counts IFG_CYCLES, then IDLE. Requests arriving during GAP are captured but not granted until IDLE.
- Outside START/SEND: ip_tx_byte_num=0 and ip_tx_data=0.
- Latency: a rise on an idle arbiter gives ip_tx_start_en high 3 cycles after the first high sample (edge register, capture, grant).
- Back-to-back frames: the minimum spacing from ip_tx_done to the next ip_tx_start_en is IFG_CYCLES+2.
- ip_tx_done outside SEND is ignored.
- Simultaneous rises on the same cycle with both idle: the round-robin pointer decides, so requester 0 wins after reset.
- Reset mid-frame: everything returns to reset values immediately. Pending requests are lost and no done pulse is issued.

Test Plan:
- Single request: req0 rises with byte_num=1 and holds high 20 cycles → exactly one ip_tx_start_en pulse, 3 cycles after the rise, with ip_tx_byte_num=1. Model ip_send returns done → req0_tx_done pulses once, and no second frame follows.
- Data routing: req0 byte_num=20, data=0x66778899 → each ip_tx_req mirrors on req0_tx_req, ip_tx_data=0x66778899, and req1_tx_req stays 0.
- Contention: req0 and req1 rise on the same cycle with byte_num 8 and 12 → req0 is served first (len 8), then req1 (len 12). The gap from done to the second start is ≥14 cycles. grant goes 0→1.
- Fairness: req0 re-requests immediately after each done while req1 has one request pending → the order is 0,1,0. Requester 0 is never served twice consecutively while req1 is pending.
- Length errors: byte_num=0, then byte_num=1473 → err_len pulses twice and ip_tx_start_en never asserts.
- Watchdog and reset: with TIMEOUT_CYCLES=64 and ip_tx_done never asserted → err_timeout and req0_tx_done pulse 64 cycles after SEND entry, and a pending req1 is served afterwards. A later rst_n low mid-SEND → all outputs are 0 on the same cycle.
